// File: rtl/rr_mux_reg.sv
// rr_mux_reg -- registered N-to-1 channel multiplexer with round-robin arbitration.
//
// Several producers offer words on valid/ready channels. One is granted per
// cycle, and its word is captured into a single output register that a
// consumer drains through its own valid/ready handshake. A new word can load
// in the same cycle the held word drains, so the block sustains one word per
// clock when the consumer never stalls.
//
// Build option:
//   RR_MUX_FIXED_PRIO_EN  when defined, the search always starts at channel 0,
//                         so the lowest valid index wins and no round-robin
//                         pointer exists. When undefined (the default), the
//                         search starts at the channel after the last winner.
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of input channels (1..16)
//   SEL_W     derived width of OUT_SEL, max(1, clog2(CHANNELS))
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   IN_DATA    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID   per-channel valid
//   IN_READY   per-channel ready, one-hot or zero, combinational
//   OUT_DATA   registered output word
//   OUT_VALID  output register holds a word
//   OUT_READY  consumer accepts the held word
//   OUT_SEL    channel that supplied OUT_DATA
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [SEL_W-1:0]          OUT_SEL
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic [SEL_W-1:0] sel_reg;

  // Index where the arbitration search begins.
  logic [SEL_W-1:0] ptr;

  logic             load_en;
  logic             grant_valid;
  logic             take;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_found;

  logic [WIDTH-1:0] chan_data [CHANNELS];

  // The output register can accept a word when it is empty or draining now.
  assign load_en     = !RST && (!valid_reg || OUT_READY);
  assign grant_valid = |IN_VALID;
  assign take        = load_en && grant_valid;

  // Circular search split into two linear ones: the lowest valid index at or
  // above ptr wins; failing that, the wrap-around winner is simply the lowest
  // valid index overall (every valid index is then below ptr).
  // Iterating downwards lets the lowest qualifying index overwrite last.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (IN_VALID[i]) begin
        lo_idx = SEL_W'(i);
        if (SEL_W'(i) >= ptr) begin
          hi_idx   = SEL_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign grant_idx = hi_found ? hi_idx : lo_idx;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = IN_DATA[gi*WIDTH +: WIDTH];
      assign IN_READY[gi]  = take && (grant_idx == SEL_W'(gi));
    end
  endgenerate

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  // Advance past the winner, wrapping explicitly so non-power-of-two
  // channel counts return to 0 rather than to an unused index.
  always_comb begin
    if (grant_idx == SEL_W'(CHANNELS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_reg <= '0;
    end else if (take) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;
`endif

  // Output register: load on a grant, otherwise empty out when drained.
  // A stall (full and not ready) keeps everything as it is.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sel_reg   <= '0;
    end else if (take) begin
      data_reg  <= chan_data[grant_idx];
      sel_reg   <= grant_idx;
      valid_reg <= 1'b1;
    end else if (OUT_READY) begin
      valid_reg <= 1'b0;
    end
  end

  assign OUT_DATA  = data_reg;
  assign OUT_VALID = valid_reg;
  assign OUT_SEL   = sel_reg;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg: one 4x8 instance (unit a) and one 3x12 instance
// (unit b), each compared every cycle against a behavioural reference model
// of arbitration and the output register, plus directed checks of the
// scenarios of interest and a randomized phase.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // unit a: CHANNELS=4, WIDTH=8
  logic        rst_a;
  logic [3:0]  v_a;
  logic [31:0] d_a;
  logic        r_a;
  logic [3:0]  rdy_a;
  logic [7:0]  od_a;
  logic        ov_a;
  logic [1:0]  os_a;

  // unit b: CHANNELS=3, WIDTH=12
  logic        rst_b;
  logic [2:0]  v_b;
  logic [35:0] d_b;
  logic        r_b;
  logic [2:0]  rdy_b;
  logic [11:0] od_b;
  logic        ov_b;
  logic [1:0]  os_b;

  rr_mux_reg #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .CLK(clk), .RST(rst_a), .IN_DATA(d_a), .IN_VALID(v_a), .IN_READY(rdy_a),
    .OUT_DATA(od_a), .OUT_VALID(ov_a), .OUT_READY(r_a), .OUT_SEL(os_a)
  );

  rr_mux_reg #(.WIDTH(12), .CHANNELS(3)) dut_b (
    .CLK(clk), .RST(rst_b), .IN_DATA(d_b), .IN_VALID(v_b), .IN_READY(rdy_b),
    .OUT_DATA(od_b), .OUT_VALID(ov_b), .OUT_READY(r_b), .OUT_SEL(os_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per unit (0 = a, 1 = b).
  int          nch [2] = '{4, 3};
  int          m_ptr [2];
  logic        m_valid [2];
  logic [11:0] m_data [2];
  int          m_sel [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First valid channel scanning circularly from the search start, -1 if none.
  function automatic int model_grant(input int u, input logic [3:0] v);
    int p;
`ifdef RR_MUX_FIXED_PRIO_EN
    p = 0;
`else
    p = m_ptr[u];
`endif
    for (int k = 0; k < nch[u]; k++) begin
      int idx;
      idx = (p + k) % nch[u];
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input int u, input logic rst, input logic rdy,
                            input int g, input logic [11:0] word);
    if (rst) begin
      m_valid[u] = 1'b0;
      m_data[u]  = '0;
      m_sel[u]   = 0;
      m_ptr[u]   = 0;
    end else if ((!m_valid[u] || rdy) && g >= 0) begin
      m_valid[u] = 1'b1;
      m_data[u]  = word;
      m_sel[u]   = g;
      m_ptr[u]   = (g + 1) % nch[u];
    end else if (rdy) begin
      m_valid[u] = 1'b0;
    end
  endtask

  // One clock: check ready against the model before the edge, advance the
  // model at the edge, then check the registered outputs.
  task automatic step();
    int         ga, gb;
    logic [3:0] er_a;
    logic [2:0] er_b;
    logic [3:0] vb;
    logic [11:0] wa, wb;
    #2;
    ga   = model_grant(0, v_a);
    er_a = '0;
    if (!rst_a && (!m_valid[0] || r_a) && ga >= 0) er_a[ga] = 1'b1;
    chk("a_in_ready", {12'b0, rdy_a}, {12'b0, er_a});
    vb   = {1'b0, v_b};
    gb   = model_grant(1, vb);
    er_b = '0;
    if (!rst_b && (!m_valid[1] || r_b) && gb >= 0) er_b[gb] = 1'b1;
    chk("b_in_ready", {13'b0, rdy_b}, {13'b0, er_b});
    wa = (ga >= 0) ? {4'b0, d_a[ga*8 +: 8]} : 12'h0;
    wb = (gb >= 0) ? d_b[gb*12 +: 12] : 12'h0;
    @(posedge clk);
    #1;
    model_edge(0, rst_a, r_a, ga, wa);
    model_edge(1, rst_b, r_b, gb, wb);
    $display("t=%0t a: v=%b rdy=%b -> ov=%b od=%h os=%0d | b: v=%b rdy=%b -> ov=%b od=%h os=%0d",
             $time, v_a, rdy_a, ov_a, od_a, os_a, v_b, rdy_b, ov_b, od_b, os_b);
    chk("a_out_valid", {15'b0, ov_a}, {15'b0, m_valid[0]});
    chk("a_out_data",  {8'b0, od_a}, {4'b0, m_data[0]});
    chk("a_out_sel",   {14'b0, os_a}, 16'(m_sel[0]));
    chk("b_out_valid", {15'b0, ov_b}, {15'b0, m_valid[1]});
    chk("b_out_data",  {4'b0, od_b}, {4'b0, m_data[1]});
    chk("b_out_sel",   {14'b0, os_b}, 16'(m_sel[1]));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_valid[u] = 1'b0; m_data[u] = '0; m_sel[u] = 0;
    end
    rst_a = 1'b1; v_a = 4'b1111; d_a = 32'hA3A2A1A0; r_a = 1'b1;
    rst_b = 1'b1; v_b = 3'b000;  d_b = '0;           r_b = 1'b1;
    @(posedge clk); #1;

    // Reset held two cycles with every channel valid.
    step();
    step();
    chk("rst_out_valid", {15'b0, ov_a}, 16'h0);
    chk("rst_out_data",  {8'b0, od_a}, 16'h0);

    // Round-robin streaming, one word per cycle.
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stream_valid", {15'b0, ov_a}, 16'h1);
`ifdef RR_MUX_FIXED_PRIO_EN
      chk("stream_sel", {14'b0, os_a}, 16'h0);
`else
      chk("stream_sel",  {14'b0, os_a}, 16'(k % 4));
      chk("stream_data", {8'b0, od_a}, 16'(8'hA0 + (k % 4)));
`endif
    end

    // Backpressure: load 5C from channel 2, stall three cycles.
    v_a = 4'b0100; d_a = 32'h005C0000;
    step();
    chk("bp_load", {8'b0, od_a}, 16'h5C);
    r_a = 1'b0; v_a = 4'b1011; d_a = 32'h77006655;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_rdy",  {12'b0, rdy_a}, 16'h0);
      chk("bp_data", {8'b0, od_a}, 16'h5C);
      chk("bp_sel",  {14'b0, os_a}, 16'h2);
    end
    r_a = 1'b1;
    step();

    // Drain and load in the same cycle: no bubble.
    v_a = 4'b0010; d_a = 32'h00003E00;
    step();
    chk("dl_valid", {15'b0, ov_a}, 16'h1);
    chk("dl_data",  {8'b0, od_a}, 16'h3E);

    // Reset in the middle of a stall.
    r_a = 1'b0; v_a = 4'b0000;
    step();
    rst_a = 1'b1;
    step();
    chk("rst_mid_valid", {15'b0, ov_a}, 16'h0);
    chk("rst_mid_sel",   {14'b0, os_a}, 16'h0);
    rst_a = 1'b0; r_a = 1'b1; v_a = 4'b1000; d_a = 32'hC4000000;
    step();
    chk("rst_mid_grant", {14'b0, os_a}, 16'h3);
    chk("rst_mid_data",  {8'b0, od_a}, 16'hC4);
    v_a = 4'b0000;
    step();

    // Three-channel unit: wrap from 2 back to 0.
    v_b = 3'b111; d_b = 36'hC02_B01_A00;
    for (int k = 0; k < 5; k++) begin
      step();
`ifndef RR_MUX_FIXED_PRIO_EN
      chk("wrap_sel", {14'b0, os_b}, 16'(k % 3));
`endif
    end
    // Sparse pattern: bring the pointer to 1, then offer channels 0 and 2.
    v_b = 3'b001;
    step();
    v_b = 3'b101;
    step();
`ifndef RR_MUX_FIXED_PRIO_EN
    chk("sparse_first", {14'b0, os_b}, 16'h2);
`endif
    step();
    chk("sparse_second", {14'b0, os_b}, 16'h0);

    // Randomized traffic on both units.
    for (int n = 0; n < 400; n++) begin
      rst_a = ($urandom_range(0, 40) == 0);
      v_a   = 4'($urandom);
      d_a   = $urandom;
      r_a   = ($urandom_range(0, 3) != 0);
      rst_b = ($urandom_range(0, 40) == 0);
      v_b   = 3'($urandom);
      d_b   = {4'($urandom), $urandom};
      r_b   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
